// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the CPU bus arbiter: FSM encodings, default error data
// and the payload captured from the winning master.
package bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: turns two requests plus the preference bit into a
// one-hot winner (bit 0 = m0, bit 1 = m1).
module rr_pick2
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] pick
);

  // A lone requester always wins; on a tie the master named by rr wins
  always_comb begin
    if (req == 2'b11) begin
      pick = rr ? 2'b10 : 2'b01;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master CPU bus arbiter: latches the winner's request, runs one bridge
// transaction with a bounded wait, then pulses done/err back to that master.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  output logic        bus_vld,
  input  logic [31:0] Bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             rr_r;
  logic             owner_r;
  logic             owner_next_s;
  logic [1:0]       pick_s;
  bus_req_t         pay_r;
  bus_req_t         pay_next_s;
  bus_req_t         m0_pay_s;
  bus_req_t         m1_pay_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             timeout_s;
  logic             busy_next_s;
  logic             done_next_s;
  logic [31:0]      rdata_next_s;
  logic [1:0]       gnt_r;
  logic [1:0]       done_r;
  logic [1:0]       err_r;
  logic [31:0]      m0_rdata_r;
  logic [31:0]      m1_rdata_r;
  logic [31:0]      bus_addr_r;
  logic [31:0]      bus_wdata_r;
  logic             bus_vld_r;
  logic             bus_wen_r;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .rr   (rr_r),
    .pick (pick_s)
  );

  assign m0_pay_s  = {m0_wen, m0_addr, m0_wdata};
  assign m1_pay_s  = {m1_wen, m1_addr, m1_wdata};
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Next state, winner/payload capture and the value to hand back on completion
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner_r;
    pay_next_s   = pay_r;
    timeout_s    = 1'b0;
    rdata_next_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (pick_s != 2'b00) begin
          state_next_s = ST_BUSY;
          owner_next_s = pick_s[1];
          pay_next_s   = pick_s[1] ? m1_pay_s : m0_pay_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // An ack on the last allowed cycle still counts as a normal completion
        if (bus_ack) begin
          state_next_s = ST_DONE;
          rdata_next_s = pay_r.wen ? 32'h0000_0000 : Bus_rdata;
        end else if (cnt_inc_s == CNT_W'(WAIT_MAX)) begin
          state_next_s = ST_DONE;
          timeout_s    = 1'b1;
          rdata_next_s = ERR_DATA;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign busy_next_s = (state_next_s == ST_BUSY);
  assign done_next_s = (state_next_s == ST_DONE);

  // State, latched request and every output are registered from the next state
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_r     <= ST_IDLE;
      rr_r        <= 1'b0;
      owner_r     <= 1'b0;
      pay_r       <= '0;
      cnt_r       <= '0;
      bus_vld_r   <= 1'b0;
      bus_wen_r   <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_wdata_r <= 32'h0000_0000;
      gnt_r       <= 2'b00;
      done_r      <= 2'b00;
      err_r       <= 2'b00;
      m0_rdata_r  <= 32'h0000_0000;
      m1_rdata_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_next_s;
      pay_r   <= pay_next_s;
      if (state_r == ST_BUSY) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= '0;
      end
      if (state_r == ST_DONE) begin
        rr_r <= ~owner_r;
      end else begin
        rr_r <= rr_r;
      end
      bus_vld_r   <= busy_next_s;
      bus_wen_r   <= busy_next_s & pay_next_s.wen;
      bus_addr_r  <= busy_next_s ? pay_next_s.addr : 32'h0000_0000;
      bus_wdata_r <= busy_next_s ? pay_next_s.wdata : 32'h0000_0000;
      gnt_r       <= {busy_next_s & owner_next_s, busy_next_s & ~owner_next_s};
      done_r      <= {done_next_s & owner_next_s, done_next_s & ~owner_next_s};
      err_r       <= {timeout_s & owner_next_s, timeout_s & ~owner_next_s};
      m0_rdata_r  <= (done_next_s & ~owner_next_s) ? rdata_next_s : 32'h0000_0000;
      m1_rdata_r  <= (done_next_s & owner_next_s) ? rdata_next_s : 32'h0000_0000;
    end
  end

  assign m0_gnt    = gnt_r[0];
  assign m1_gnt    = gnt_r[1];
  assign m0_done   = done_r[0];
  assign m1_done   = done_r[1];
  assign m0_err    = err_r[0];
  assign m1_err    = err_r[1];
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;
  assign bus_vld   = bus_vld_r;
  assign Bus_wen   = bus_wen_r;
  assign Bus_addr  = bus_addr_r;
  assign Bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of who wins, how long, and what comes back.
module tb_bus_arbiter;

  localparam int unsigned WAIT_MAX = 15;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        Bus_wen, bus_vld, bus_ack;

  int total = 0;
  int bad   = 0;

  // Model state: pending requests, their payloads, and who wins a tie
  bit          pend [2];
  logic        pw   [2];
  logic [31:0] pa   [2];
  logic [31:0] pd   [2];
  int          turn = 0;

  bus_arbiter #(.WAIT_MAX(WAIT_MAX), .ERR_DATA(ERR_DATA)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata),
    .bus_vld(bus_vld), .Bus_rdata(Bus_rdata), .bus_ack(bus_ack)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pair(input logic b0, input logic b1);
    return {30'd0, b1, b0};
  endfunction

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive_masters();
    m0_req = pend[0]; m0_wen = pw[0]; m0_addr = pa[0]; m0_wdata = pd[0];
    m1_req = pend[1]; m1_wen = pw[1]; m1_addr = pa[1]; m1_wdata = pd[1];
  endtask

  task automatic set_req(input int m, input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
    pend[m] = 1'b1; pw[m] = wen; pa[m] = addr; pd[m] = wdata;
  endtask

  task automatic rand_req(input int m);
    set_req(m, 1'($urandom_range(0, 1)), $urandom(), $urandom());
  endtask

  // One transaction starting in an IDLE cycle; d = ack-less BUSY cycles before ack
  task automatic txn(input int d, input logic [31:0] rd, input bit rereq);
    int w, len;
    bit to;
    logic        ew;
    logic [31:0] ea, ewd, erd;
    w   = (pend[0] && pend[1]) ? turn : (pend[1] ? 1 : 0);
    ew  = pw[w]; ea = pa[w]; ewd = pd[w];
    to  = (d >= int'(WAIT_MAX));
    len = to ? int'(WAIT_MAX) : d + 1;
    erd = to ? ERR_DATA : (ew ? 32'd0 : rd);
    drive_masters();
    bus_ack = 1'($urandom_range(0, 1)); Bus_rdata = $urandom();
    @(negedge cpu_clk);
    chk("idle_vld", 32'(bus_vld), 32'd0);
    chk("idle_gnt", pair(m0_gnt, m1_gnt), 32'd0);
    for (int k = 0; k < len; k++) begin
      step();
      if (w == 0) begin m0_addr = pa[0] + 32'h10; m0_wdata = ~pd[0]; end
      else begin m1_addr = pa[1] + 32'h10; m1_wdata = ~pd[1]; end
      bus_ack   = (k == d);
      Bus_rdata = (k == d) ? rd : $urandom();
      @(negedge cpu_clk);
      chk("busy_vld", 32'(bus_vld), 32'd1);
      chk("busy_gnt", pair(m0_gnt, m1_gnt), 32'd1 << w);
      chk("busy_addr", Bus_addr, ea);
      chk("busy_wen", 32'(Bus_wen), 32'(ew));
      chk("busy_wdata", Bus_wdata, ewd);
      chk("busy_done", pair(m0_done, m1_done), 32'd0);
    end
    step();
    bus_ack = 1'($urandom_range(0, 1)); Bus_rdata = $urandom();
    pend[w] = 1'b0;
    if (rereq) rand_req(w);
    drive_masters();
    @(negedge cpu_clk);
    chk("done_pulse", pair(m0_done, m1_done), 32'd1 << w);
    chk("done_err", pair(m0_err, m1_err), to ? (32'd1 << w) : 32'd0);
    chk("done_rdata", (w == 0) ? m0_rdata : m1_rdata, erd);
    chk("done_other_rdata", (w == 0) ? m1_rdata : m0_rdata, 32'd0);
    chk("done_vld", 32'(bus_vld), 32'd0);
    chk("done_gnt", pair(m0_gnt, m1_gnt), 32'd0);
    turn = 1 - w;
    step();
  endtask

  initial begin
    int d;
    pend[0] = 1'b0; pend[1] = 1'b0;
    pw[0] = 1'b0; pw[1] = 1'b0; pa[0] = 32'd0; pa[1] = 32'd0; pd[0] = 32'd0; pd[1] = 32'd0;
    drive_masters();
    m0_req = 1'b1; m1_req = 1'b1;
    bus_ack = 1'b1; Bus_rdata = 32'hDEAD_BEEF;
    cpu_rst = 1'b1;
    step(); step();
    @(negedge cpu_clk);
    chk("rst_vld", 32'(bus_vld), 32'd0);
    chk("rst_gnt", pair(m0_gnt, m1_gnt), 32'd0);
    chk("rst_done", pair(m0_done, m1_done), 32'd0);
    chk("rst_err", pair(m0_err, m1_err), 32'd0);
    chk("rst_addr", Bus_addr, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    drive_masters();
    bus_ack = 1'b0;
    cpu_rst = 1'b0;
    step();

    // Contention out of reset: m0 first, m1 next even though m0 re-requests
    set_req(0, 1'b0, 32'h0000_0100, 32'h0);
    set_req(1, 1'b1, 32'h0000_0200, 32'hA5A5_0001);
    txn(1, 32'h1111_2222, 1'b1);
    txn(0, 32'h3333_4444, 1'b1);
    // Fairness: both keep requesting, grants alternate
    for (int i = 0; i < 6; i++) txn(int'($urandom_range(0, 2)), $urandom(), 1'b1);
    while (pend[0] || pend[1]) txn(0, $urandom(), 1'b0);

    // Single read with ack on the first BUSY cycle
    set_req(0, 1'b0, 32'h0000_4000, 32'h0);
    txn(0, 32'h1234_5678, 1'b0);
    // Write timeout on m1
    set_req(1, 1'b1, 32'h0000_8000, 32'hCAFE_F00D);
    txn(int'(WAIT_MAX) + 5, 32'h0, 1'b0);
    // Ack on the last allowed cycle is a normal completion
    set_req(0, 1'b0, 32'h0000_9000, 32'h0);
    txn(int'(WAIT_MAX) - 1, 32'h5555_AAAA, 1'b0);
    // Payload hold: addr moves 0x10 -> 0x20 while busy
    set_req(0, 1'b1, 32'h0000_0010, 32'h7777_8888);
    txn(3, 32'h0, 1'b0);

    // Reset on the 3rd BUSY cycle with ack high: transaction dropped silently
    set_req(1, 1'b0, 32'h0000_0300, 32'h0);
    drive_masters();
    bus_ack = 1'b0;
    step(); step(); step();
    bus_ack = 1'b1; Bus_rdata = 32'h0BAD_0BAD; cpu_rst = 1'b1;
    @(negedge cpu_clk);
    chk("rstbusy_inflight", 32'(bus_vld), 32'd1);
    step();
    cpu_rst = 1'b0; bus_ack = 1'b0; pend[1] = 1'b0; drive_masters();
    @(negedge cpu_clk);
    chk("rstbusy_vld", 32'(bus_vld), 32'd0);
    chk("rstbusy_done", pair(m0_done, m1_done), 32'd0);
    chk("rstbusy_err", pair(m0_err, m1_err), 32'd0);
    chk("rstbusy_gnt", pair(m0_gnt, m1_gnt), 32'd0);
    turn = 0;
    step();
    @(negedge cpu_clk);
    chk("rstbusy_late_done", pair(m0_done, m1_done), 32'd0);
    step();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < 2; m++) if (!pend[m] && ($urandom_range(0, 1) == 1)) rand_req(m);
      if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
      d = ($urandom_range(0, 5) == 0) ? int'(WAIT_MAX) + 1 : int'($urandom_range(0, 4));
      txn(d, $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of cycles to wait for bus_ack before a timeout.
REQ-002 The module SHALL have parameter ERR_DATA, default 32'hFFFF_FFFF, meaning the rdata returned on timeout.
REQ-003 The module SHALL have these ports (name  direction  width  meaning):
- cpu_clk  in  1  sole clock; all state changes on the rising edge.
- cpu_rst  in  1  reset; synchronous, active-high.
- m0_req / m1_req  in  1  master request; held until mX_done.
- m0_wen / m1_wen  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_gnt / m1_gnt  out  1  master owns the bus.
- m0_done / m1_done  out  1  one-cycle completion pulse.
- m0_err / m1_err  out  1  one-cycle timeout pulse, coincident with done.
- m0_rdata / m1_rdata  out  32  read data, valid while mX_done is high.
- Bus_addr  out  32  address to the bridge.
- Bus_wen  out  1  write strobe to the bridge.
- Bus_wdata  out  32  write data to the bridge.
- bus_vld  out  1  transaction in flight.
- Bus_rdata  in  32  read data from the bridge.
- bus_ack  in  1  bridge completion; qualified by bus_vld.

Function
REQ-004 The state machine SHALL have states IDLE, BUSY and DONE.
REQ-005 In IDLE, if any mX_req is high, the arbiter SHALL choose a master, latch that master's addr, wdata and wen, and move to BUSY.
REQ-006 If only one master requests, that master SHALL win.
REQ-007 If both masters request in the same cycle, the master named by the 1-bit round-robin pointer rr SHALL win.
REQ-008 In BUSY: bus_vld=1, Bus_* SHALL be driven from the latched registers, and the owner's gnt=1.
REQ-009 In every other state, bus_vld, Bus_wen, Bus_addr, Bus_wdata and both gnt outputs SHALL be 0.
REQ-010 The arbiter SHALL sample bus_ack in BUSY.
REQ-011 On bus_ack=1 in BUSY, the arbiter SHALL capture Bus_rdata (for reads) and move to DONE.
REQ-012 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without bus_ack.
REQ-013 When the counter equals WAIT_MAX with no bus_ack, the arbiter SHALL move to DONE with rdata=ERR_DATA and flag an error.
REQ-014 In DONE, the arbiter SHALL, for exactly one cycle:
- pulse the owner's mX_done;
- present the captured rdata on mX_rdata (writes: 0);
- pulse mX_err if a timeout occurred.
REQ-015 In DONE, rr SHALL be set to the non-owner, and the next state SHALL be IDLE.
REQ-016 Minimum latency SHALL be: req seen in IDLE at cycle N -> BUSY at N+1 -> (ack at N+1) DONE at N+2 -> IDLE at N+3, giving a 3-cycle transaction.
REQ-017 A request deasserted mid-BUSY SHALL NOT abort the transaction; done SHALL still pulse.
REQ-018 Payload changes during BUSY SHALL be ignored, because payload is latched in IDLE.
REQ-019 bus_ack outside BUSY SHALL be ignored.
REQ-020 A non-owner request SHALL wait; it SHALL be serviced in the IDLE cycle after DONE, before any re-request by the owner.
REQ-021 Outputs not owned SHALL read 0: the non-owner's gnt, done, err and rdata.

Reset
REQ-022 On cpu_rst=1 at a clock edge, the state SHALL become IDLE, rr=0 (m0 preferred), and the counter, latched registers and all outputs SHALL be 0.
REQ-023 Reset SHALL override any state, including mid-BUSY.
REQ-024 A transaction in flight at reset SHALL be dropped; no done or err SHALL be pulsed.
REQ-025 Reset SHALL take priority over a simultaneous bus_ack.

Structure
REQ-026 State encodings (IDLE/BUSY/DONE) and the default ERR_DATA SHALL be defined as constants in the shared defines header used by the CPU.
REQ-027 The round-robin selection (two requests + rr -> one-hot winner) SHALL be one sub-module named rr_pick2.
REQ-028 All other logic SHALL be inline in bus_arbiter.

Verification
REQ-029 Single read: m0 requests a read at 0x0000_4000 and bus_ack is high on the first BUSY cycle with Bus_rdata=0x1234_5678 -> m0_done pulses 2 cycles after the request is sampled, with m0_rdata=0x1234_5678.
REQ-030 Contention: m0 and m1 both request from reset -> m0 is served first (rr=0), then m1 in the next IDLE, with no m0 re-grant in between.
REQ-031 Fairness: m0 and m1 request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-032 Timeout: m1 writes with bus_ack held 0 -> after 15 BUSY cycles, m1_done=m1_err=1 and m1_rdata=0xFFFF_FFFF.
REQ-033 Reset mid-BUSY: cpu_rst=1 on the 3rd BUSY cycle while bus_ack=1 -> next cycle is IDLE, and done, err and bus_vld are all 0.
REQ-034 Payload hold: m0_addr changes 0x10 -> 0x20 during BUSY -> Bus_addr stays 0x10 throughout.
